// File: rtl/binary_mul_seq_if.sv
// Handshake and data bundle for the sequential shift-add multiplier.
// The master drives the operation request and the slave returns status and product.
interface binary_mul_seq_if #(
  parameter int W = 8
);
  logic             en;
  logic             start;
  logic             signed_mode;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   P;

  modport master (
    output en, start, signed_mode, A, B,
    input  busy, done, P
  );

  modport slave (
    input  en, start, signed_mode, A, B,
    output busy, done, P
  );
endinterface

// File: rtl/binary_mul_seq.sv
// Sequential shift-add multiplier, unsigned or two's-complement per operation.
// The operands are reduced to magnitudes at start and multiplied unsigned, one
// multiplier bit per enabled cycle. The sign is applied once in the FIX state.
module binary_mul_seq #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  binary_mul_seq_if.slave   bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]   OP_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ACC_ONE  = {{(2*W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  state_t           state_r;
  logic             busy_r;
  logic             done_r;
  logic [2*W-1:0]   p_r;
  logic [2*W-1:0]   acc_r;
  logic [2*W-1:0]   mcand_r;   // magnitude of A, pre-shifted by the bit position
  logic [W-1:0]     mplier_r;  // magnitude of B, consumed LSB first
  logic [CW-1:0]    cnt_r;
  logic             neg_r;

  // Magnitude of an operand; the most negative value maps to 2^(W-1) unsigned.
  function automatic logic [W-1:0] op_mag(input logic [W-1:0] v, input logic sm);
    logic [W-1:0] r;
    if (sm && v[W-1]) begin
      r = (~v) + OP_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Operation FSM: accept, accumulate one partial product per cycle, apply sign.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      p_r      <= '0;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      neg_r    <= 1'b0;
    end else if (bus.en) begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mcand_r  <= {{W{1'b0}}, op_mag(bus.A, bus.signed_mode)};
            mplier_r <= op_mag(bus.B, bus.signed_mode);
            neg_r    <= bus.signed_mode & (bus.A[W-1] ^ bus.B[W-1]);
            acc_r    <= '0;
            cnt_r    <= '0;
            state_r  <= RUN;
            busy_r   <= 1'b1;
          end
        end
        RUN: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          // A zero magnitude negates to zero, so there is no "-0" result.
          p_r     <= neg_r ? ((~acc_r) + ACC_ONE) : acc_r;
          done_r  <= 1'b1;
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.P    = p_r;

endmodule

// File: tb/tb_binary_mul_seq.sv
// Scoreboard bench for binary_mul_seq at W=8, W=5 and W=16.
// Stimulus pushes expected products; per-width monitors pop them on done.
module tb_binary_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  binary_mul_seq_if #(.W(8))  i8  ();
  binary_mul_seq_if #(.W(5))  i5  ();
  binary_mul_seq_if #(.W(16)) i16 ();

  binary_mul_seq #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  binary_mul_seq #(.W(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(i5.slave));
  binary_mul_seq #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));

  typedef struct {
    longint p;
    int     due;
  } exp8_t;

  exp8_t  q8[$];
  longint q5[$];
  longint q16[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt8    = 0;   // enabled edges seen by the W=8 DUT
  int tcnt     = 0;   // all clock edges
  bit en_last8 = 1'b0;
  exp8_t mon_e;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edge bookkeeping for latency measurement.
  always @(posedge clk) begin
    tcnt     <= tcnt + 1;
    en_last8 <= i8.en;
    if (i8.en) ecnt8 <= ecnt8 + 1;
  end

  // W=8 monitor: a done after an enabled edge is a fresh completion.
  always @(negedge clk) begin
    if (i8.done && en_last8) begin
      if (q8.size() == 0) begin
        chk("stray_done8", 1, 0);
      end else begin
        mon_e = q8.pop_front();
        chk("p8", longint'(i8.P), mon_e.p);
        chk("lat8", longint'(ecnt8), longint'(mon_e.due));
      end
    end
  end

  // W=5 monitor (en held high throughout).
  always @(negedge clk) begin
    if (i5.done) begin
      if (q5.size() == 0) chk("stray_done5", 1, 0);
      else chk("p5", longint'(i5.P), q5.pop_front());
    end
  end

  // W=16 monitor (en held high throughout).
  always @(negedge clk) begin
    if (i16.done) begin
      if (q16.size() == 0) chk("stray_done16", 1, 0);
      else chk("p16", longint'(i16.P), q16.pop_front());
    end
  end

  // Called at a negedge: drive a request, advance one cycle, record expectation.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input longint exp, input bit accept);
    i8.start = 1'b1; i8.A = a; i8.B = b; i8.signed_mode = sm;
    @(negedge clk);
    i8.start = 1'b0;
    if (accept) q8.push_back('{p: exp, due: ecnt8 + 9});
  endtask

  task automatic wait_done(input int which);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      case (which)
        5:       seen = i5.done;
        16:      seen = i16.done;
        default: seen = i8.done;
      endcase
    end
    if (!seen) chk("timeout_done", 0, 1);
  endtask

  task automatic run5(input logic [4:0] a, input logic [4:0] b, input logic sm);
    longint av, bv;
    av = sm ? longint'($signed(a)) : longint'(a);
    bv = sm ? longint'($signed(b)) : longint'(b);
    q5.push_back((av * bv) & 64'h3FF);
    i5.start = 1'b1; i5.A = a; i5.B = b; i5.signed_mode = sm;
    @(negedge clk);
    i5.start = 1'b0;
    wait_done(5);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm);
    longint av, bv;
    av = sm ? longint'($signed(a)) : longint'(a);
    bv = sm ? longint'($signed(b)) : longint'(b);
    q16.push_back((av * bv) & 64'hFFFF_FFFF);
    i16.start = 1'b1; i16.A = a; i16.B = b; i16.signed_mode = sm;
    @(negedge clk);
    i16.start = 1'b0;
    wait_done(16);
  endtask

  // Hard stop in case something wedges the scheduler.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0x0, expected 0x1");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t0;
    i8.en = 1'b1;  i8.start = 1'b0;  i8.signed_mode = 1'b0;  i8.A = '0;  i8.B = '0;
    i5.en = 1'b1;  i5.start = 1'b0;  i5.signed_mode = 1'b0;  i5.A = '0;  i5.B = '0;
    i16.en = 1'b1; i16.start = 1'b0; i16.signed_mode = 1'b0; i16.A = '0; i16.B = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", longint'(i8.busy), 0);
    chk("rst_done", longint'(i8.done), 0);
    chk("rst_p",    longint'(i8.P), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned 255*255 with busy profile
    issue8(8'd255, 8'd255, 1'b0, 64'hFE01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("busy_run", longint'(i8.busy), 1);
      chk("done_low", longint'(i8.done), 0);
      @(negedge clk);
    end
    chk("busy_9th", longint'(i8.busy), 1);
    @(negedge clk);
    chk("done_pulse", longint'(i8.done), 1);
    chk("busy_fall", longint'(i8.busy), 0);
    chk("p_ff", longint'(i8.P), 64'hFE01);

    // Signed and unsigned directed products
    @(negedge clk); issue8(8'h80, 8'h80, 1'b1, 64'h4000, 1'b1); wait_done(8);
    @(negedge clk); issue8(8'hFF, 8'h7F, 1'b1, 64'hFF81, 1'b1); wait_done(8);
    @(negedge clk); issue8(8'h00, 8'hFB, 1'b1, 64'h0000, 1'b1); wait_done(8);
    @(negedge clk); issue8(8'hFD, 8'h05, 1'b1, 64'hFFF1, 1'b1); wait_done(8);
    @(negedge clk); issue8(8'h7F, 8'h7F, 1'b1, 64'h3F01, 1'b1); wait_done(8);
    @(negedge clk); issue8(8'd200, 8'd3, 1'b0, 64'h0258, 1'b1); wait_done(8);

    // Back-to-back: start in the done cycle
    @(negedge clk); issue8(8'd7, 8'd9, 1'b0, 64'd63, 1'b1); wait_done(8);
    issue8(8'd3, 8'd4, 1'b0, 64'd12, 1'b1);
    chk("b2b_busy", longint'(i8.busy), 1);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_hold_p", longint'(i8.P), 64'd63);
      @(negedge clk);
    end
    wait_done(8);

    // Start while busy is ignored
    @(negedge clk); issue8(8'd10, 8'd11, 1'b0, 64'd110, 1'b1);
    @(negedge clk); @(negedge clk);
    issue8(8'd50, 8'd60, 1'b0, 64'd0, 1'b0);
    wait_done(8);
    @(negedge clk);
    chk("ignored_idle", longint'(i8.busy), 0);

    // Enable stall mid-RUN and during done
    @(negedge clk); issue8(8'hF9, 8'h0D, 1'b1, 64'hFFA5, 1'b1);
    t0 = tcnt;
    repeat (3) @(negedge clk);
    i8.en = 1'b0;
    repeat (5) @(negedge clk);
    i8.en = 1'b1;
    wait_done(8);
    chk("stall_delay", longint'(tcnt - t0), 14);
    i8.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_done_hi", longint'(i8.done), 1);
      chk("stall_p", longint'(i8.P), 64'hFFA5);
    end
    i8.en = 1'b1;
    @(negedge clk);
    chk("stall_done_clr", longint'(i8.done), 0);

    // Reset mid-RUN aborts
    @(negedge clk); issue8(8'd255, 8'd255, 1'b0, 64'hFE01, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q8.delete();
    chk("abort_busy", longint'(i8.busy), 0);
    chk("abort_done", longint'(i8.done), 0);
    chk("abort_p",    longint'(i8.P), 0);
    repeat (15) @(negedge clk);
    chk("abort_idle", longint'(i8.busy), 0);
    issue8(8'd6, 8'd7, 1'b0, 64'd42, 1'b1); wait_done(8);

    // W=5 sweep: directed extremes then random, both modes
    @(negedge clk);
    run5(5'h10, 5'h10, 1'b1);
    run5(5'h1F, 5'h1F, 1'b0);
    run5(5'h1F, 5'h01, 1'b1);
    for (int i = 0; i < 16; i++) run5(5'($urandom), 5'($urandom), 1'($urandom));

    // W=16 sweep
    run16(16'h8000, 16'h8000, 1'b1);
    run16(16'hFFFF, 16'hFFFF, 1'b0);
    run16(16'h0000, 16'hFFFE, 1'b1);
    for (int i = 0; i < 16; i++) run16(16'($urandom), 16'($urandom), 1'($urandom));

    repeat (5) @(negedge clk);
    chk("q8_empty",  longint'(q8.size()), 0);
    chk("q5_empty",  longint'(q5.size()), 0);
    chk("q16_empty", longint'(q16.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/binary_mul_seq.md
# binary_mul_seq

Parametrised sequential shift-add multiplier for the binary multiplier family. It multiplies two W-bit operands, either unsigned or two's-complement signed, selected per operation. Each operation takes W+1 enabled cycles and is controlled by a start/busy/done handshake. It replaces the fixed-width, single-cycle array multipliers wherever area matters more than throughput. The result register keeps the family's clock-enable and hold behaviour.

## Interface
- W, default 8: operand width in bits; legal range 2..32; result width is 2W.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- en  input  1  global clock enable; when low, every register holds its value.
- start  input  1  request a new multiply; sampled only when en=1 and busy=0.
- signed_mode  input  1  at start: 1 = two's-complement operands and result, 0 = unsigned.
- A  input  W  multiplicand; sampled at start.
- B  input  W  multiplier; sampled at start.
- busy  output  1  high while an operation is in flight; equals (state != IDLE).
- done  output  1  one-enabled-cycle pulse; P holds a new result.
- P  output  2W  product register; holds the last result until the next completion.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE with en=1 and start=1:
  - in signed mode, latch magnitudes |A| and |B| (W bits unsigned; -2^(W-1) gives magnitude 2^(W-1)); in unsigned mode, latch A and B raw;
  - latch neg = signed_mode & (A[W-1] ^ B[W-1]);
  - accumulator (2W bits) = 0, bit counter = 0;
  - go to RUN.
- RUN, each enabled cycle:
  - if multiplier bit[counter] = 1, accumulator += multiplicand << counter; the accumulator is 2W bits wide and never overflows;
  - counter increments;
  - after processing bit W-1, go to FIX.
- FIX, one enabled cycle:
  - P = neg ? (~acc + 1) : acc, truncated to 2W bits;
  - done = 1;
  - go to IDLE.
- Signed extremes: (-2^(W-1))·(-2^(W-1)) = 2^(2W-2) fits the signed 2W range exactly. Zero times a negative operand yields P = 0, never "-0".
- done is 1 only in the cycle after the FIX edge. The next enabled edge clears it unless that edge is another FIX.
- start while busy=1 is ignored: no queueing, no error flag, and the in-flight operands are unaffected.
- start and done may coincide: start in the cycle where done=1 is accepted, because the state is IDLE.
- A, B and signed_mode are don't-care outside the start-accept cycle.

## Timing
- Reset is synchronous, takes priority over en and start, and sets: state=IDLE, busy=0, done=0, P=0, accumulator, counter, operand registers and neg all 0.
- Reset mid-operation aborts the operation: no done pulse, and P reads 0.
- Start accepted at enabled edge k:
  - busy=1 after edge k;
  - RUN occupies edges k+1..k+W;
  - FIX occurs at edge k+W+1, where P and done update and busy falls.
  - Latency from the start edge to a valid P is W+1 enabled edges. Maximum throughput is one result per W+1 cycles.
- en=0 freezes the FSM, counter, accumulator, P and done. A done pulse therefore stretches across disabled cycles and clears at the next enabled edge. Latency is counted in enabled edges only.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- W=8, unsigned, A=255, B=255, start for one cycle, en=1: busy is high for 9 cycles; done pulses at the 9th edge after start; P=0xFE01 (65025).
- W=8, signed: -128·-128 gives P=0x4000; -1·127 gives P=0xFF81; 0·-5 gives P=0x0000. Each result arrives 9 edges after its start.
- W=8: assert start again in the cycle done=1 (A=3, B=4, unsigned). The second operation is accepted with no idle gap and returns P=12 nine edges later; P holds the first result until then.
- W=8: assert start with different operands while busy=1. The request is ignored, and the original product completes unchanged after 9 edges.
- W=8: drop en for 5 cycles mid-RUN, and also during the done cycle. Completion is delayed by exactly 5 cycles, done stays high through the stall, and P is correct.
- W=8: pull rst_n low for one cycle at RUN cycle 4. At the next edge busy=0, done=0 and P=0, with no stray done afterwards. Also run a randomised W=5 and W=16 sweep against a reference multiply in both modes.
